// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter and sequencer sharing one UART transmitter between
//   N_REQ byte requesters. A winning requester's byte and the current line
//   configuration are latched at the IDLE decision and held steady toward the
//   transmitter for the whole frame. The transmitter's sending flag marks the
//   frame start and end. A one-cycle done (ack) or abort (ack_err) pulse goes
//   back to the served requester.
//
// Ports
//   clk             in   system clock
//   reset           in   asynchronous, active-low reset
//   req             in   per-requester request level, held until acknowledged
//   req_data        in   byte of requester i at [8i+7:8i]
//   cfg_baud_rate   in   baud select, sampled at the grant decision
//   cfg_parity_type in   parity select, sampled at the grant decision
//   ack             out  one-cycle pulse: byte of requester fully sent
//   ack_err         out  one-cycle pulse: byte aborted, transmitter never started
//   grant_id        out  requester currently served (valid while busy)
//   busy            out  high in every state except IDLE
//   tx_enable       out  transmitter enable
//   tx_din          out  transmitter data byte
//   tx_baud_rate    out  transmitter baud select
//   tx_parity_type  out  transmitter parity select
//   tx_sending      in   transmitter frame-in-progress flag
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 1023,
  parameter int GAP_CYCLES    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [1:0]           cfg_baud_rate,
  input  logic [1:0]           cfg_parity_type,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     ack_err,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 tx_enable,
  output logic [7:0]           tx_din,
  output logic [1:0]           tx_baud_rate,
  output logic [1:0]           tx_parity_type,
  input  logic                 tx_sending
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int SW    = PTR_W + 1;
  localparam int TO_W  = $clog2(START_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_DONE,
    GAP
  } state_t;

  // With no inter-frame gap the frame end returns straight to IDLE.
  localparam state_t AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;
  logic [7:0]         din_q, din_d;
  logic [1:0]         baud_q, baud_d;
  logic [1:0]         par_q, par_d;
  logic               en_q, en_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   ack_err_q, ack_err_d;

  logic               any_req;
  logic [PTR_W-1:0]   win;
  logic [SW-1:0]      scan;
  logic [N_REQ-1:0]   gnt_oh;

  // Round-robin pick: scan from rr_q upward (mod N_REQ). The loop runs from
  // the farthest position back to rr_q so the last hit is the nearest one.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    scan    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_q} + SW'(k);
      if (scan >= SW'(N_REQ)) begin
        scan = scan - SW'(N_REQ);
      end
      if (req[scan[PTR_W-1:0]]) begin
        any_req = 1'b1;
        win     = scan[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_oh[i] = (gnt_q == PTR_W'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    din_d     = din_q;
    baud_d    = baud_q;
    par_d     = par_q;
    en_d      = en_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ack_d     = '0;
    ack_err_d = '0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = win;
          din_d   = req_data[{win, 3'b000} +: 8];
          baud_d  = cfg_baud_rate;
          par_d   = cfg_parity_type;
          rr_d    = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
          state_d = LOAD;
        end
      end

      // Data and config are already stable on the TX inputs; enable follows.
      LOAD: begin
        en_d     = 1'b1;
        to_cnt_d = '0;
        state_d  = WAIT_START;
      end

      // A sending flag already high here (TX still draining) counts as start.
      WAIT_START: begin
        if (tx_sending) begin
          en_d    = 1'b0;
          state_d = WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          en_d      = 1'b0;
          ack_err_d = gnt_oh;
          gap_cnt_d = '0;
          state_d   = AFTER_FRAME;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!tx_sending) begin
          ack_d     = gnt_oh;
          gap_cnt_d = '0;
          state_d   = AFTER_FRAME;
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      gnt_q     <= '0;
      din_q     <= 8'h00;
      baud_q    <= 2'b00;
      par_q     <= 2'b00;
      en_q      <= 1'b0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      ack_q     <= '0;
      ack_err_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      din_q     <= din_d;
      baud_q    <= baud_d;
      par_q     <= par_d;
      en_q      <= en_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ack_q     <= ack_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign ack            = ack_q;
  assign ack_err        = ack_err_q;
  assign grant_id       = 3'(gnt_q);
  assign busy           = (state_q != IDLE);
  assign tx_enable      = en_q;
  assign tx_din         = din_q;
  assign tx_baud_rate   = baud_q;
  assign tx_parity_type = par_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART_TX_top_module between N byte requesters.
- Latches the winning requester's byte and the line configuration (baud_rate, parity_type), then drives the transmitter's enable/din.
- Tracks the transmitter's sending flag to detect frame start and end, and returns a per-requester done/error acknowledge.
- Sits between the application-side byte sources and the single TX instance on the board.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- START_TIMEOUT, 1023, max clk cycles in WAIT_START for tx_sending to rise before abort.
- GAP_CYCLES, 16, idle clk cycles inserted between consecutive frames (0 allowed = no gap).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester transmit request; level, held until its ack.
- req_data  input  8*N_REQ  byte of requester i at [8i+7:8i].
- cfg_baud_rate  input  2  baud select forwarded to TX.
- cfg_parity_type  input  2  parity select forwarded to TX.
- ack  output  N_REQ  one-cycle pulse: requester's byte fully sent.
- ack_err  output  N_REQ  one-cycle pulse: requester's byte aborted on start timeout.
- grant_id  output  3  index of the requester currently being served; valid while busy.
- busy  output  1  high in every state except IDLE.
- tx_enable  output  1  to TX enable.
- tx_din  output  8  to TX din.
- tx_baud_rate  output  2  to TX baud_rate.
- tx_parity_type  output  2  to TX parity_type.
- tx_sending  input  1  from TX sending.

Behaviour:
- Interface rule: one clock, clk; reset is asynchronous and active-low; every register is cleared immediately when reset=0.
- Reset values: state=IDLE, rr_ptr=0, ack=0, ack_err=0, grant_id=0, busy=0, tx_enable=0, tx_din=8'h00, tx_baud_rate=2'b00, tx_parity_type=2'b00, counters=0.
- Arbitration, in IDLE with any req bit set:
  - Winner is the first set bit scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - grant_id is latched to the winner.
  - tx_din is latched from the winner's req_data slice.
  - tx_baud_rate and tx_parity_type are latched from the cfg_* inputs.
  - rr_ptr becomes (winner+1) mod N_REQ.
  - Next state is LOAD.
- Config stability: cfg_* changes are ignored until the next IDLE decision. Outputs to TX are stable for the whole frame.
- LOAD: lasts 1 cycle with tx_enable=0 (data/config set up ahead of enable). Next state is WAIT_START.
- WAIT_START:
  - tx_enable=1 and the timeout counter increments each cycle.
  - On tx_sending=1, go to WAIT_DONE and drop tx_enable on that same edge (registered, so tx_enable is 0 from the next cycle).
  - If the counter reaches START_TIMEOUT with tx_sending still 0: pulse ack_err[grant_id], set tx_enable=0, go to GAP.
- WAIT_DONE: tx_enable=0. On tx_sending=0, pulse ack[grant_id] and go to GAP.
- GAP: counts GAP_CYCLES cycles with tx_enable=0, then returns to IDLE. With GAP_CYCLES=0 the next state is IDLE directly.
- Minimum arbitration cadence: one grant per frame; a requester is re-granted only after every other active requester has been served once.
- Withdrawal: req deasserted after its grant has no effect; the latched frame completes and the ack is still issued.
- A req bit still high during the cycle its ack pulses is treated as a new request at the next IDLE.
- tx_sending already high at LOAD (TX still draining): WAIT_START treats it as started. The bench must not rely on this; GAP covers the normal case.
- Reset mid-frame: all outputs return to reset values immediately. No ack or ack_err is issued for the interrupted byte.
- busy=1 in LOAD, WAIT_START, WAIT_DONE and GAP.
- Exactly one of ack/ack_err pulses per grant, each for exactly one cycle.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hA5, cfg_parity_type=2'b10, TX model raises sending 3 cycles after enable and holds it 50 cycles -> tx_din=8'hA5 and tx_parity_type=2'b10 before tx_enable rises; tx_enable high exactly until the cycle after sending rises; one ack[0] pulse after sending falls; busy low GAP_CYCLES+1 cycles later.
- Round-robin: req=4'b1111 held, data 8'h11/22/33/44 -> grant order 0,1,2,3,0; tx_din sequence 11,22,33,44,11; ack pulses in the same order.
- Fairness after skip: rr_ptr=2 with req=4'b0011 -> grant 0 then 1; later req=4'b0101 -> grant 2 before 0.
- Start timeout: TX model never asserts sending, START_TIMEOUT=20 -> ack_err[grant] pulses after 20 cycles in WAIT_START, no ack, tx_enable=0, next requester served after the gap.
- Config latch: change cfg_baud_rate 00->11 during WAIT_DONE -> tx_baud_rate stays 00 until the next grant, then 11.
- Reset mid-frame: assert reset=0 in WAIT_DONE -> busy, tx_enable, ack and ack_err are 0 immediately; after release, a pending req is granted from rr_ptr=0.
